// File: rtl/seq_bcd_display_if.sv
// Handshake and display bus of the sequential binary-to-BCD seven-segment driver.
// The master modport is the value producer; the slave modport is the display driver.
interface seq_bcd_display_if #(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [IN_WIDTH-1:0]   in_data;
  logic                  blank_lz;
  logic [7*DIGITS-1:0]   seg;
  logic                  done;
  logic                  overflow;

  modport master (
    output in_valid, in_data, blank_lz,
    input  in_ready, seg, done, overflow
  );

  modport slave (
    input  in_valid, in_data, blank_lz,
    output in_ready, seg, done, overflow
  );
endinterface

// File: rtl/seq_bcd_display.sv
// Sequential double-dabble converter driving DIGITS active-low seven-segment digits,
// with leading-zero blanking and dash display when the value does not fit.
module seq_bcd_display #(
  parameter int IN_WIDTH = 14,
  parameter int DIGITS   = 4
) (
  input logic              clk,
  input logic              rst_n,
  seq_bcd_display_if.slave bus
);
  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + IN_WIDTH;
  localparam int CW = $clog2(IN_WIDTH + 1);
  localparam logic [63:0] LIMIT = 64'd10 ** DIGITS;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    UPDATE = 2'd2
  } state_t;

  state_t              state_r;
  logic [SW-1:0]       sreg_r;
  logic [CW-1:0]       cnt_r;
  logic                blank_r;
  logic                ovf_pend_r;
  logic                in_ready_r;
  logic                done_r;
  logic                ovf_r;
  logic [7*DIGITS-1:0] seg_r;
  logic [7*DIGITS-1:0] seg_next_s;
  logic                lead_s;
  logic [3:0]          dig_s;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h18;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // One double-dabble iteration: add-3 correction on every BCD nibble, then shift left.
  function automatic logic [SW-1:0] dabble_step(input logic [SW-1:0] r);
    logic [SW-1:0] t;
    t = r;
    for (int k = 0; k < DIGITS; k++) begin
      t[IN_WIDTH+4*k +: 4] = (t[IN_WIDTH+4*k +: 4] >= 4'd5) ?
                             (t[IN_WIDTH+4*k +: 4] + 4'd3) : t[IN_WIDTH+4*k +: 4];
    end
    return {t[SW-2:0], 1'b0};
  endfunction

  assign bus.in_ready = in_ready_r;
  assign bus.seg      = seg_r;
  assign bus.done     = done_r;
  assign bus.overflow = ovf_r;

  // Digit encoding of the finished BCD word; scans from the top digit to track leading zeros.
  always_comb begin
    seg_next_s = {(7*DIGITS){1'b1}};
    lead_s     = 1'b1;
    dig_s      = 4'd0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      dig_s = sreg_r[IN_WIDTH+4*k +: 4];
      if (ovf_pend_r) begin
        seg_next_s[7*k +: 7] = 7'h3F;
      end else if (blank_r && lead_s && (k != 0) && (dig_s == 4'd0)) begin
        seg_next_s[7*k +: 7] = 7'h7F;
      end else begin
        seg_next_s[7*k +: 7] = seg7(dig_s);
      end
      lead_s = lead_s & (dig_s == 4'd0);
    end
  end

  // Control FSM, conversion datapath and registered display outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      sreg_r     <= {SW{1'b0}};
      cnt_r      <= {CW{1'b0}};
      blank_r    <= 1'b0;
      ovf_pend_r <= 1'b0;
      in_ready_r <= 1'b1;
      done_r     <= 1'b0;
      ovf_r      <= 1'b0;
      seg_r      <= {(7*DIGITS){1'b1}};
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            sreg_r     <= {{BW{1'b0}}, bus.in_data};
            blank_r    <= bus.blank_lz;
            ovf_pend_r <= (64'(bus.in_data) >= LIMIT);
            cnt_r      <= {CW{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= SHIFT;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        SHIFT: begin
          sreg_r <= dabble_step(sreg_r);
          cnt_r  <= cnt_r + CW'(1);
          if (cnt_r == CW'(IN_WIDTH - 1)) begin
            state_r <= UPDATE;
          end else begin
            state_r <= SHIFT;
          end
        end
        UPDATE: begin
          seg_r      <= seg_next_s;
          ovf_r      <= ovf_pend_r;
          done_r     <= 1'b1;
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          in_ready_r <= 1'b1;
          state_r    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: doc/seq_bcd_display.md
# seq_bcd_display

Registered, parametrised binary-to-decimal seven-segment display driver. Accepts an unsigned binary value through a valid/ready handshake and converts it with a sequential double-dabble (one bit per clock). It then drives DIGITS active-low seven-segment digits with optional leading-zero blanking and overflow indication. Sits between any counter or score logic and the board HEX displays; it replaces the purely combinational conversion path so that wide values close timing.

## Interface
- IN_WIDTH, default 14: width of the binary input.
- DIGITS, default 4: number of decimal digits driven; the overflow limit is 10^DIGITS.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  in_data is presented.
- in_ready  out  1  block can accept; high only in IDLE.
- in_data  in  IN_WIDTH  unsigned value to display.
- blank_lz  in  1  leading-zero blanking enable; sampled at accept.
- seg  out  7*DIGITS  segment outputs, digit 0 (units) in bits [6:0]; per digit the bit order is GFEDCBA (bit 6 = G); active-low.
- done  out  1  one-cycle pulse when seg has been updated.
- overflow  out  1  registered; 1 when the last accepted value was ≥ 10^DIGITS.

## Operation
- FSM states: IDLE, SHIFT, UPDATE.
  - IDLE: in_ready=1.
    - On in_valid=1, load the shift register with {4*DIGITS zeros, in_data}.
    - Latch blank_lz.
    - Latch ovf_pending = (in_data ≥ 10^DIGITS), compared at full width with no truncation.
    - Clear the iteration counter and go to SHIFT.
  - SHIFT: exactly IN_WIDTH iterations, one per cycle. Each iteration:
    - Add 3 to every BCD nibble that is ≥ 5.
    - Then shift the whole register left by 1.
    - Leave SHIFT for UPDATE after the IN_WIDTH-th iteration.
  - UPDATE: write seg, overflow and done; return to IDLE.
- The shift register is 4*DIGITS+IN_WIDTH bits. The iteration counter is $clog2(IN_WIDTH+1) bits.
- Active-low digit codes: 0=0x40, 1=0x79, 2=0x24, 3=0x30, 4=0x19, 5=0x12, 6=0x02, 7=0x78, 8=0x00, 9=0x18. Blank=0x7F; dash=0x3F (G only).
- Overflow: every digit shows dash and overflow=1. The BCD result is discarded.
- Blanking (latched blank_lz=1, no overflow):
  - Digit k (k≥1) is blank if it and all higher digits are zero.
  - Digit 0 is never blanked.
- seg holds its value between updates. in_valid/in_data are ignored outside IDLE.

## Timing
- Reset values: seg all 0x7F (all digits dark), done=0, overflow=0, state IDLE, in_ready=1.
- Accept on edge E0 (in_valid & in_ready). Iterations occur on edges E1..E_IN_WIDTH. seg, overflow and done update on edge E_(IN_WIDTH+1).
- Latency from accept to seg valid: IN_WIDTH+1 cycles. done is high during the cycle following E_(IN_WIDTH+1).
- in_ready is low from the cycle after E0 through the UPDATE cycle. It is high again in the same cycle done is high.
- Back-to-back: a new accept is allowed in the done cycle. Peak throughput is one value per IN_WIDTH+2 cycles.
- Reset mid-conversion: the conversion is aborted immediately. Outputs return to reset values, no done is produced, and the in-flight value is lost.
- No output depends combinationally on in_data or in_valid; in_ready is decoded from state only.
- Arithmetic: nibble add-3 is modulo 16 with no carry into the next nibble. This is safe because corrected nibbles never exceed 12 before the shift.

## Test plan
- Defaults, in_data=1234, blank_lz=0 -> in_ready low for 15 cycles.
  - done on the 16th cycle after accept.
  - seg = {0x79,0x24,0x30,0x19} (digit3..0), overflow=0.
- in_data=0, blank_lz=1 -> seg={0x7F,0x7F,0x7F,0x40}.
- in_data=7, blank_lz=0 -> seg={0x40,0x40,0x40,0x78}.
- in_data=9999 -> all digits 0x18, overflow=0.
- in_data=10000 -> all digits 0x3F, overflow=1.
- in_data=16383 -> all digits 0x3F, overflow=1.
- Back-to-back and in_valid held high:
  - Continuous in_valid with values 5 then 42 (blank_lz=1) -> exactly two done pulses 16 cycles apart.
  - Final seg={0x7F,0x7F,0x19,0x24}.
- Reset mid-conversion: assert rst_n=0 for one cycle at iteration 6 of in_data=8888 -> seg all 0x7F, no done, in_ready=1.
  - Next accept of 3 converts normally.
- Parameter sweep, DIGITS=6, IN_WIDTH=20:
  - in_data=999999 -> six digits 0x18, done 21 cycles after accept.
  - in_data=1000000 -> six dashes, overflow=1.
